// File: rtl/keypad_lock_pkg.sv
// rtl/keypad_lock_pkg.sv - shared state encoding and key constants for the keypad lock
package keypad_lock_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3,
    S_ALARM   = 3'd4
  } lock_state_t;

  localparam logic [4:0] KEY_START = 5'd16;
  localparam logic [4:0] KEY_LOCK  = 5'd17;
  localparam logic [4:0] KEY_PROG  = 5'd18;

  // Codes 0..15 are digits; everything with bit 4 set is a command or junk.
  function automatic logic is_digit_key(input logic [4:0] k);
    return !k[4];
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter timing the lockout residency
module lockout_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load wins over counting; the counter parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - parametrised keypad lock with retry limit, lockout and re-programming
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int                         CODE_LEN     = 8,
  parameter int                         DIGIT_W      = 4,
  parameter int                         MAX_TRIES    = 3,
  parameter int                         LOCKOUT_CYC  = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 32'h1234_5678
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [4:0]                    key_code,
  input  logic [CODE_LEN*DIGIT_W-1:0]   code_in,
  output logic [2:0]                    state,
  output logic                          unlocked,
  output logic                          alarm,
  output logic                          locked_out,
  output logic [$clog2(CODE_LEN+1)-1:0] digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic                          prog_done
);

  localparam int IDX_W  = $clog2(CODE_LEN+1);
  localparam int FAIL_W = $clog2(MAX_TRIES+1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYC+1);

  lock_state_t                 state_q, state_n;
  logic [CODE_LEN*DIGIT_W-1:0] code_reg;
  logic                        mismatch, mismatch_n;
  logic [IDX_W-1:0]            idx_n;
  logic [FAIL_W-1:0]           fail_n;
  logic                        prog_n;
  logic                        code_we;
  logic                        timer_load;
  logic                        timer_done;
  logic [DIGIT_W-1:0]          exp_digit;
  logic                        mismatch_upd;
  logic                        key_is_digit;

  lockout_timer #(.W(LOCK_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LOCK_W'(LOCKOUT_CYC-1)),
    .done     (timer_done)
  );

  // Stored digit expected at the current position; digit 0 lives in the MSBs.
  always_comb begin
    exp_digit = code_reg[(CODE_LEN-1-int'(digit_idx))*DIGIT_W +: DIGIT_W];
  end

  assign key_is_digit = is_digit_key(key_code);
  assign mismatch_upd = mismatch | (key_code[DIGIT_W-1:0] != exp_digit);

  // Next-state and datapath decisions; only a completed sequence is judged.
  always_comb begin
    state_n    = state_q;
    idx_n      = digit_idx;
    mismatch_n = mismatch;
    fail_n     = fail_cnt;
    prog_n     = 1'b0;
    code_we    = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      S_INIT: begin
        if (key_valid && key_code == KEY_START) begin
          state_n    = S_ENTRY;
          idx_n      = '0;
          mismatch_n = 1'b0;
        end
      end
      S_ENTRY: begin
        if (key_valid && key_is_digit) begin
          if (digit_idx == IDX_W'(CODE_LEN-1)) begin
            idx_n      = '0;
            mismatch_n = 1'b0;
            if (!mismatch_upd) begin
              state_n = S_OPEN;
              fail_n  = '0;
            end else if (fail_cnt == FAIL_W'(MAX_TRIES-1)) begin
              state_n = S_ALARM;
              fail_n  = FAIL_W'(MAX_TRIES);
            end else begin
              state_n    = S_LOCKOUT;
              fail_n     = fail_cnt + 1'b1;
              timer_load = 1'b1;
            end
          end else begin
            idx_n      = digit_idx + 1'b1;
            mismatch_n = mismatch_upd;
          end
        end else if (key_valid && key_code == KEY_START) begin
          idx_n      = '0;
          mismatch_n = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (timer_done) begin
          state_n = S_INIT;
        end
      end
      S_OPEN: begin
        if (key_valid && key_code == KEY_LOCK) begin
          state_n = S_INIT;
        end else if (key_valid && key_code == KEY_PROG) begin
          code_we = 1'b1;
          prog_n  = 1'b1;
        end
      end
      S_ALARM: begin
        state_n = S_ALARM;
      end
      default: begin
        state_n    = S_INIT;
        idx_n      = '0;
        mismatch_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset beats any key in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_INIT;
      code_reg  <= DEFAULT_CODE;
      digit_idx <= '0;
      mismatch  <= 1'b0;
      fail_cnt  <= '0;
      prog_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      digit_idx <= idx_n;
      mismatch  <= mismatch_n;
      fail_cnt  <= fail_n;
      prog_done <= prog_n;
      if (code_we) begin
        code_reg <= code_in;
      end
    end
  end

  assign state      = state_q;
  assign unlocked   = (state_q == S_OPEN);
  assign alarm      = (state_q == S_ALARM);
  assign locked_out = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - scoreboard bench for keypad_lock_ctrl in two parameterisations
module tb_keypad_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic [31:0] code_in = '0;
  logic [31:0] cin = 32'hAAAA_0001;

  logic [2:0] st0, st1;
  logic       unl0, unl1, alm0, alm1, lko0, lko1, pd0, pd1;
  logic [3:0] idx0;
  logic [2:0] idx1;
  logic [1:0] fc0, fc1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  keypad_lock_ctrl u_dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .code_in(code_in),
    .state(st0), .unlocked(unl0), .alarm(alm0), .locked_out(lko0),
    .digit_idx(idx0), .fail_cnt(fc0), .prog_done(pd0)
  );

  keypad_lock_ctrl #(
    .CODE_LEN(4), .DIGIT_W(3), .MAX_TRIES(3), .LOCKOUT_CYC(1), .DEFAULT_CODE(12'o7012)
  ) u_dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .code_in(code_in[11:0]),
    .state(st1), .unlocked(unl1), .alarm(alm1), .locked_out(lko1),
    .digit_idx(idx1), .fail_cnt(fc1), .prog_done(pd1)
  );

  // Reference model: the entered digits are kept as a list and judged as a whole.
  int          P_LEN  [2] = '{8, 4};
  int          P_DW   [2] = '{4, 3};
  int          P_MAX  [2] = '{3, 3};
  int          P_LCYC [2] = '{16, 1};
  logic [31:0] P_DEF  [2] = '{32'h1234_5678, 32'h0000_0E0A};

  int          m_st   [2];
  int          m_n    [2];
  int          m_fail [2];
  int          m_left [2];
  bit          m_prog [2];
  logic [31:0] m_code [2];
  int          m_ent  [2][8];

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] idx;
    logic [1:0] fail;
    logic       prog;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int mdig(input int i, input int k);
    return int'((m_code[i] >> ((P_LEN[i]-1-k)*P_DW[i])) & ((32'd1 << P_DW[i]) - 1));
  endfunction

  function automatic void model_step(input int i, input bit r, input bit kv, input int kc,
                                     input logic [31:0] ci);
    bit ok;
    if (!r) begin
      m_st[i] = 0; m_n[i] = 0; m_fail[i] = 0; m_left[i] = 0; m_prog[i] = 0;
      m_code[i] = P_DEF[i];
      return;
    end
    m_prog[i] = 0;
    case (m_st[i])
      0: if (kv && kc == 16) begin m_st[i] = 1; m_n[i] = 0; end
      1: if (kv && kc < 16) begin
           m_ent[i][m_n[i]] = kc % (1 << P_DW[i]);
           m_n[i]++;
           if (m_n[i] == P_LEN[i]) begin
             ok = 1;
             for (int k = 0; k < P_LEN[i]; k++) if (m_ent[i][k] != mdig(i, k)) ok = 0;
             m_n[i] = 0;
             if (ok) begin
               m_st[i] = 2; m_fail[i] = 0;
             end else begin
               m_fail[i]++;
               if (m_fail[i] == P_MAX[i]) m_st[i] = 4;
               else begin m_st[i] = 3; m_left[i] = P_LCYC[i]; end
             end
           end
         end else if (kv && kc == 16) m_n[i] = 0;
      3: begin m_left[i]--; if (m_left[i] == 0) m_st[i] = 0; end
      2: if (kv && kc == 17) m_st[i] = 0;
         else if (kv && kc == 18) begin
           m_code[i] = ci & ((32'd1 << (P_LEN[i]*P_DW[i])) - 1);
           m_prog[i] = 1;
         end
      default: ;
    endcase
  endfunction

  function automatic exp_t snap(input int i);
    exp_t e;
    e.st = 3'(m_st[i]); e.idx = 4'(m_n[i]); e.fail = 2'(m_fail[i]); e.prog = m_prog[i];
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock edge: inputs applied, model advanced, expectation queued after the edge.
  task automatic step(input bit r, input bit kv, input int kc, input logic [31:0] ci);
    exp_t e0, e1;
    rst = r; key_valid = kv; key_code = 5'(kc); code_in = ci;
    model_step(0, r, kv, kc, ci); e0 = snap(0);
    model_step(1, r, kv, kc, ci); e1 = snap(1);
    @(posedge clk);
    q0.push_back(e0); q1.push_back(e1);
    #1;
  endtask

  task automatic key(input int kc, input bit gap);
    step(1'b1, 1'b1, kc, cin);
    if (gap && ($urandom % 2 == 1)) step(1'b1, 1'b0, int'($urandom % 32), cin);
  endtask

  task automatic enter_code(input logic [31:0] c, input int n);
    key(16, 1'b1);
    for (int k = 0; k < n; k++) key(int'(c[(n-1-k)*4 +: 4]), k != n-1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, int'($urandom % 32), cin);
  endtask

  // Monitor: every cycle both DUTs present status, compared against the queued model output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_state", int'(st0), int'(e.st));
        chk("d0_unlocked", int'(unl0), int'(e.st == 3'd2));
        chk("d0_alarm", int'(alm0), int'(e.st == 3'd4));
        chk("d0_locked_out", int'(lko0), int'(e.st == 3'd3));
        chk("d0_digit_idx", int'(idx0), int'(e.idx));
        chk("d0_fail_cnt", int'(fc0), int'(e.fail));
        chk("d0_prog_done", int'(pd0), int'(e.prog));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_state", int'(st1), int'(e.st));
        chk("d1_unlocked", int'(unl1), int'(e.st == 3'd2));
        chk("d1_alarm", int'(alm1), int'(e.st == 3'd4));
        chk("d1_locked_out", int'(lko1), int'(e.st == 3'd3));
        chk("d1_digit_idx", int'(idx1), int'(e.idx));
        chk("d1_fail_cnt", int'(fc1), int'(e.fail));
        chk("d1_prog_done", int'(pd1), int'(e.prog));
      end
    end
  end

  initial begin
    int kc;
    step(1'b0, 1'b0, 0, cin);
    step(1'b0, 1'b1, 16, cin);
    chk("rst_state", int'(st0), 0);
    chk("rst_idx", int'(idx0), 0);

    enter_code(32'h1234_5678, 8);
    chk("dir_open", int'(unl0), 1);
    chk("dir_open_fail", int'(fc0), 0);
    chk("dir_open_idx", int'(idx0), 0);

    step(1'b1, 1'b1, 18, cin);
    chk("dir_prog_pulse", int'(pd0), 1);
    step(1'b1, 1'b0, 18, cin);
    chk("dir_prog_clear", int'(pd0), 0);
    key(17, 1'b1);
    enter_code(32'hAAAA_0001, 8);
    chk("dir_new_code_open", int'(unl0), 1);
    key(17, 1'b0);

    enter_code(32'h1234_5678, 8);
    chk("dir_old_code_lockout", int'(lko0), 1);
    chk("dir_fail1", int'(fc0), 1);
    idle(15);
    chk("dir_lockout_last", int'(lko0), 1);
    idle(1);
    chk("dir_lockout_exit", int'(st0), 0);

    enter_code(32'h9234_5678, 8);
    idle(16);
    enter_code(32'h9234_5678, 8);
    chk("dir_alarm", int'(alm0), 1);
    chk("dir_alarm_fail", int'(fc0), 3);
    key(16, 1'b0);
    key(17, 1'b0);
    chk("dir_alarm_sticky", int'(alm0), 1);
    step(1'b0, 1'b1, 16, cin);
    chk("dir_alarm_reset", int'(alm0), 0);

    key(16, 1'b1); key(1, 1'b1); key(2, 1'b1); key(3, 1'b1);
    enter_code(32'h1234_5678, 8);
    chk("dir_restart_open", int'(unl0), 1);
    key(17, 1'b1);

    enter_code(32'h0000_7012, 4);
    chk("dir_small_open", int'(unl1), 1);
    key(17, 1'b0);
    enter_code(32'h0000_1111, 4);
    chk("dir_small_lockout", int'(lko1), 1);
    step(1'b1, 1'b0, 0, cin);
    chk("dir_small_lockout_exit", int'(st1), 0);
    key(16, 1'b0); key(7, 1'b0); key(0, 1'b0);
    step(1'b0, 1'b1, 1, cin);
    chk("dir_small_rst_idx", int'(idx1), 0);
    chk("dir_small_rst_state", int'(st1), 0);

    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = int'($urandom % 100);
      if (sel < 8) kc = 16;
      else if (sel < 12) kc = 17;
      else if (sel < 17) kc = 18;
      else if (sel < 20) kc = 19 + int'($urandom % 13);
      else if (sel < 60 && m_st[0] == 1) kc = mdig(0, m_n[0]);
      else kc = int'($urandom % 16);
      cin = ($urandom % 2 == 1) ? 32'h1234_5678 : $urandom;
      step(($urandom % 600) != 0, ($urandom % 3) != 0, kc, cin);
    end

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) chk("queue_drain", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
